// File: rtl/cacheline_adaptor_pkg.sv
// Shared types and sizing helpers for the cache-line to memory-burst adaptor.
package cacheline_adaptor_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } adaptor_state_e;

  function automatic int unsigned bursts_of(input int unsigned line_w, input int unsigned burst_w);
    return line_w / burst_w;
  endfunction

  function automatic int unsigned ofs_w_of(input int unsigned line_w);
    return $clog2(line_w / 8);
  endfunction

  // Beat counter width, kept at least one bit for single-beat configurations.
  function automatic int unsigned beat_w_of(input int unsigned bursts);
    return (bursts > 1) ? $clog2(bursts) : 1;
  endfunction

endpackage

// File: rtl/cacheline_burst_adaptor_if.sv
// Cache-line request side plus burst memory bus; master is the adaptor, slave is cache + memory.
interface cacheline_burst_adaptor_if #(
  parameter int unsigned LINE_W  = 256,
  parameter int unsigned BURST_W = 64,
  parameter int unsigned ADDR_W  = 32
);
  logic [ADDR_W-1:0]  line_addr_i;
  logic               line_read_i;
  logic               line_write_i;
  logic [LINE_W-1:0]  line_i;
  logic [LINE_W-1:0]  line_o;
  logic               line_resp_o;
  logic [ADDR_W-1:0]  pmem_addr_o;
  logic               pmem_read_o;
  logic               pmem_write_o;
  logic [BURST_W-1:0] pmem_wdata_o;
  logic [BURST_W-1:0] pmem_rdata_i;
  logic               pmem_resp_i;

  modport master (
    input  line_addr_i, line_read_i, line_write_i, line_i,
    output line_o, line_resp_o,
    output pmem_addr_o, pmem_read_o, pmem_write_o, pmem_wdata_o,
    input  pmem_rdata_i, pmem_resp_i
  );

  modport slave (
    output line_addr_i, line_read_i, line_write_i, line_i,
    input  line_o, line_resp_o,
    input  pmem_addr_o, pmem_read_o, pmem_write_o, pmem_wdata_o,
    output pmem_rdata_i, pmem_resp_i
  );
endinterface

// File: rtl/line_beat_buffer.sv
// Line-wide staging register: beat-indexed fill for reads, parallel load for writes,
// beat-indexed mux out for feeding write beats.
module line_beat_buffer #(
  parameter int unsigned LINE_W  = 256,
  parameter int unsigned BURST_W = 64,
  parameter int unsigned BEAT_W  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [LINE_W-1:0]  load_data,
  input  logic               wr_en,
  input  logic [BEAT_W-1:0]  wr_beat,
  input  logic [BURST_W-1:0] wr_data,
  input  logic [BEAT_W-1:0]  rd_beat,
  output logic [LINE_W-1:0]  line_q,
  output logic [BURST_W-1:0] rd_data_c
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_q <= '0;
    end else if (load) begin
      line_q <= load_data;
    end else if (wr_en) begin
      line_q[wr_beat*BURST_W +: BURST_W] <= wr_data;
    end
  end

  assign rd_data_c = line_q[rd_beat*BURST_W +: BURST_W];

endmodule

// File: rtl/cacheline_burst_adaptor.sv
// Converts one line-wide cache request into BURSTS memory-bus beats.
// Optional perf counters are built only when CACHELINE_ADAPTOR_PERF_EN is defined.
module cacheline_burst_adaptor
  import cacheline_adaptor_pkg::*;
#(
  parameter int unsigned LINE_W  = 256,
  parameter int unsigned BURST_W = 64,
  parameter int unsigned ADDR_W  = 32
) (
  input  logic        clk,
  input  logic        rst,
  cacheline_burst_adaptor_if.master bus,
  output logic [31:0] perf_reads_o,
  output logic [31:0] perf_writes_o,
  output logic [31:0] perf_stall_o
);

  localparam int unsigned BURSTS = bursts_of(LINE_W, BURST_W);
  localparam int unsigned OFS_W  = ofs_w_of(LINE_W);
  localparam int unsigned BEAT_W = beat_w_of(BURSTS);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURSTS - 1);

  adaptor_state_e     state_q, state_d;
  logic [BEAT_W-1:0]  beat_q, beat_d;
  logic [ADDR_W-1:0]  addr_d;
  logic               load_c, fill_c, last_beat_c;
  logic [LINE_W-1:0]  buf_line;
  logic [BURST_W-1:0] buf_beat_c;
  logic [LINE_W-1:0]  read_line_c;
  logic               unused_ofs;

  assign unused_ofs  = ^bus.line_addr_i[OFS_W-1:0];
  assign last_beat_c = (beat_q == LAST_BEAT);

  line_beat_buffer #(
    .LINE_W  (LINE_W),
    .BURST_W (BURST_W),
    .BEAT_W  (BEAT_W)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .load      (load_c),
    .load_data (bus.line_i),
    .wr_en     (fill_c),
    .wr_beat   (beat_q),
    .wr_data   (bus.pmem_rdata_i),
    .rd_beat   (beat_d),
    .line_q    (buf_line),
    .rd_data_c (buf_beat_c)
  );

  // Next state, beat and address; request inputs only matter in IDLE.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    addr_d  = bus.pmem_addr_o;
    load_c  = 1'b0;
    fill_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.line_write_i) begin
          state_d = WRITE;
          addr_d  = {bus.line_addr_i[ADDR_W-1:OFS_W], OFS_W'(0)};
          load_c  = 1'b1;
        end else if (bus.line_read_i) begin
          state_d = READ;
          addr_d  = {bus.line_addr_i[ADDR_W-1:OFS_W], OFS_W'(0)};
        end
      end
      READ: begin
        if (bus.pmem_resp_i) begin
          fill_c = 1'b1;
          if (last_beat_c) state_d = DONE;
          else             beat_d  = beat_q + BEAT_W'(1);
        end
      end
      WRITE: begin
        if (bus.pmem_resp_i) begin
          if (last_beat_c) state_d = DONE;
          else             beat_d  = beat_q + BEAT_W'(1);
        end
      end
      DONE: begin
        beat_d  = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Full line as it stands once the final read beat lands.
  always_comb begin
    read_line_c = buf_line;
    read_line_c[beat_q*BURST_W +: BURST_W] = bus.pmem_rdata_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= IDLE;
      beat_q           <= '0;
      bus.pmem_addr_o  <= '0;
      bus.pmem_read_o  <= 1'b0;
      bus.pmem_write_o <= 1'b0;
      bus.pmem_wdata_o <= '0;
      bus.line_resp_o  <= 1'b0;
      bus.line_o       <= '0;
    end else begin
      state_q          <= state_d;
      beat_q           <= beat_d;
      bus.pmem_addr_o  <= addr_d;
      bus.pmem_read_o  <= (state_d == READ);
      bus.pmem_write_o <= (state_d == WRITE);
      bus.line_resp_o  <= (state_d == DONE);
      // Buffer is loaded on this same edge, so the first write beat comes straight from line_i.
      if (state_d != WRITE) bus.pmem_wdata_o <= '0;
      else if (load_c)      bus.pmem_wdata_o <= bus.line_i[BURST_W-1:0];
      else                  bus.pmem_wdata_o <= buf_beat_c;
      if (state_q == READ && bus.pmem_resp_i && last_beat_c) bus.line_o <= read_line_c;
    end
  end

`ifdef CACHELINE_ADAPTOR_PERF_EN
  localparam logic [31:0] SAT = 32'hFFFF_FFFF;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_reads_o  <= '0;
      perf_writes_o <= '0;
      perf_stall_o  <= '0;
    end else begin
      if (state_q == READ && state_d == DONE && perf_reads_o != SAT)
        perf_reads_o <= perf_reads_o + 32'd1;
      if (state_q == WRITE && state_d == DONE && perf_writes_o != SAT)
        perf_writes_o <= perf_writes_o + 32'd1;
      if ((state_q == READ || state_q == WRITE) && perf_stall_o != SAT)
        perf_stall_o <= perf_stall_o + 32'd1;
    end
  end
`else
  assign perf_reads_o  = '0;
  assign perf_writes_o = '0;
  assign perf_stall_o  = '0;
`endif

endmodule

// File: tb/tb_cacheline_burst_adaptor.sv
// Self-checking bench: burst memory model on the bus side, scoreboard queues for lines and write beats.
module tb_cacheline_burst_adaptor;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cacheline_burst_adaptor_if bus ();
  logic [31:0] perf_reads, perf_writes, perf_stall;

  cacheline_burst_adaptor dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .perf_reads_o  (perf_reads),
    .perf_writes_o (perf_writes),
    .perf_stall_o  (perf_stall)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  logic [63:0]  mem     [int unsigned];
  logic [63:0]  ref_mem [int unsigned];
  logic [255:0] exp_lines[$];
  logic [63:0]  wq[$];
  logic [255:0] last_read = '0;
  int           mcnt = 0;
  int           resp_pulses = 0;
  int           exp_reads = 0;
  int           exp_writes = 0;

  // Memory: up to 4 beats per asserted transaction, with random idle gaps between beats.
  always @(negedge clk) begin
    int unsigned idx;
    if (rst || !(bus.pmem_read_o || bus.pmem_write_o)) begin
      mcnt = 0;
      bus.pmem_resp_i  = 1'b0;
      bus.pmem_rdata_i = '0;
    end else begin
      if (bus.pmem_resp_i) mcnt++;
      bus.pmem_resp_i = 1'b0;
      if (mcnt < 4 && $urandom_range(0, 3) != 0) begin
        idx = bus.pmem_addr_o / 8 + mcnt;
        if (bus.pmem_read_o) begin
          bus.pmem_rdata_i = mem.exists(idx) ? mem[idx] : 64'h0;
        end else begin
          mem[idx] = bus.pmem_wdata_o;
          if (wq.size() > 0) check("wbeat", bus.pmem_wdata_o, wq.pop_front());
          else               check("wbeat_queue", 64'(wq.size()), 64'd1);
        end
        bus.pmem_resp_i = 1'b1;
      end
    end
  end

  always @(negedge clk) if (bus.line_resp_o) resp_pulses++;

  function automatic logic [255:0] ref_line(input logic [31:0] a);
    logic [255:0] ln;
    int unsigned  b;
    b = (a & 32'hFFFF_FFE0) / 8;
    for (int k = 0; k < 4; k++) ln[k*64 +: 64] = ref_mem.exists(b + k) ? ref_mem[b + k] : 64'h0;
    return ln;
  endfunction

  task automatic preload(input logic [31:0] a, input logic [255:0] ln);
    int unsigned b;
    b = (a & 32'hFFFF_FFE0) / 8;
    for (int k = 0; k < 4; k++) begin
      mem[b + k]     = ln[k*64 +: 64];
      ref_mem[b + k] = ln[k*64 +: 64];
    end
  endtask

  task automatic start(input logic rd, input logic wr, input logic [31:0] a, input logic [255:0] wl);
    int unsigned b;
    bus.line_addr_i  = a;
    bus.line_read_i  = rd;
    bus.line_write_i = wr;
    bus.line_i       = wl;
    if (wr) begin
      b = (a & 32'hFFFF_FFE0) / 8;
      for (int k = 0; k < 4; k++) begin
        wq.push_back(wl[k*64 +: 64]);
        ref_mem[b + k] = wl[k*64 +: 64];
      end
      exp_lines.push_back(last_read);
    end else begin
      exp_lines.push_back(ref_line(a));
    end
  endtask

  // Waits for line_resp_o; bus must come up exactly lat cycles after the request was seen.
  task automatic wait_done(input bit wr, input int lat, input logic [31:0] a);
    bit got = 0;
    bit saw_rd = 0;
    logic [255:0] e;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (i < lat - 1) check("bus_idle_pre", 1'(bus.pmem_read_o | bus.pmem_write_o), 1'b0);
      else if (i == lat - 1) begin
        check("bus_on", wr ? bus.pmem_write_o : bus.pmem_read_o, 1'b1);
        check("pmem_addr", bus.pmem_addr_o, a & 32'hFFFF_FFE0);
      end
      if (bus.pmem_read_o) saw_rd = 1;
      if (bus.line_resp_o) begin
        got = 1;
        break;
      end
    end
    check("resp_seen", got, 1'b1);
    if (wr) check("no_pmem_read", saw_rd, 1'b0);
    if (got && exp_lines.size() > 0) begin
      e = exp_lines.pop_front();
      check(wr ? "line_o_kept" : "line_o", bus.line_o, e);
      if (wr) exp_writes++;
      else begin
        exp_reads++;
        last_read = e;
      end
    end
  endtask

  task automatic release_req();
    bus.line_read_i  = 1'b0;
    bus.line_write_i = 1'b0;
    @(negedge clk);
    check("resp_one_cycle", bus.line_resp_o, 1'b0);
    check("bus_released", 1'(bus.pmem_read_o | bus.pmem_write_o), 1'b0);
  endtask

  task automatic check_perf();
`ifdef CACHELINE_ADAPTOR_PERF_EN
    check("perf_reads", perf_reads, 256'(exp_reads));
    check("perf_writes", perf_writes, 256'(exp_writes));
`else
    check("perf_reads", perf_reads, 256'd0);
    check("perf_writes", perf_writes, 256'd0);
    check("perf_stall", perf_stall, 256'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] wl, rl, l60, l300;
    int p0;
    rst = 1'b1;
    bus.line_addr_i  = '0;
    bus.line_read_i  = 1'b0;
    bus.line_write_i = 1'b0;
    bus.line_i       = '0;
    for (int k = 0; k < 4; k++) begin
      l60[k*64 +: 64]  = 64'h1111_1111_1111_1111 * 64'(k + 1);
      l300[k*64 +: 64] = {$urandom, $urandom};
      wl[k*64 +: 64]   = 64'hA5A5_A5A5_A5A5_A500 | 64'(k + 1);
      rl[k*64 +: 64]   = {$urandom, $urandom};
    end
    preload(32'h0000_0060, l60);
    preload(32'h0000_0200, ~l300);
    preload(32'h0000_0300, l300);

    repeat (2) @(negedge clk);
    check("rst_resp", bus.line_resp_o, 1'b0);
    check("rst_rd", bus.pmem_read_o, 1'b0);
    check("rst_wr", bus.pmem_write_o, 1'b0);
    check("rst_addr", bus.pmem_addr_o, 32'h0);
    check("rst_line", bus.line_o, 256'h0);
    check("rst_perf", perf_reads | perf_writes | perf_stall, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    start(1'b1, 1'b0, 32'h0000_0060, '0);
    wait_done(1'b0, 1, 32'h0000_0060);
    check("line_60", bus.line_o, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                  64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});
    release_req();

    // Reset after two of four read beats; the interrupted line must not leak into the next read.
    start(1'b1, 1'b0, 32'h0000_0200, '0);
    for (int i = 0; i < 200 && mcnt < 2; i++) @(negedge clk);
    check("two_beats_seen", 1'(mcnt >= 2), 1'b1);
    #1 rst = 1'b1;
    #1;
    check("arst_rd", bus.pmem_read_o, 1'b0);
    check("arst_resp", bus.line_resp_o, 1'b0);
    check("arst_addr", bus.pmem_addr_o, 32'h0);
    check("arst_line", bus.line_o, 256'h0);
    bus.line_read_i = 1'b0;
    exp_lines.delete();
    exp_reads  = 0;
    exp_writes = 0;
    last_read  = '0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    start(1'b1, 1'b0, 32'h0000_0300, '0);
    wait_done(1'b0, 1, 32'h0000_0300);
    release_req();

    start(1'b0, 1'b1, 32'h0000_1084, wl);
    wait_done(1'b1, 1, 32'h0000_1084);
    release_req();
    start(1'b1, 1'b0, 32'h0000_1080, '0);
    wait_done(1'b0, 1, 32'h0000_1080);
    check("readback_1080", bus.line_o, wl);
    release_req();

    start(1'b1, 1'b1, 32'h0000_2000, rl);
    wait_done(1'b1, 1, 32'h0000_2000);
    release_req();
    start(1'b1, 1'b0, 32'h0000_2000, '0);
    wait_done(1'b0, 1, 32'h0000_2000);
    release_req();
    check_perf();

    // Read request held through DONE: second read starts one cycle after IDLE re-entry.
    p0 = resp_pulses;
    start(1'b1, 1'b0, 32'h0000_0060, '0);
    wait_done(1'b0, 1, 32'h0000_0060);
    start(1'b1, 1'b0, 32'h0000_0060, '0);
    wait_done(1'b0, 2, 32'h0000_0060);
    release_req();
    repeat (3) @(negedge clk);
    check("b2b_pulses", 256'(resp_pulses - p0), 256'd2);
    check_perf();
`ifdef CACHELINE_ADAPTOR_PERF_EN
    check("perf_stall_nz", 1'(perf_stall != 0), 1'b1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
